// File: rtl/alu_cdb_stage_pkg.sv
// alu_cdb_stage_pkg
//   Shared constants for the ALU execution / CDB stage: datapath widths,
//   the null ROB tag, boolean aliases and the internal opcode codes.
//   The opcode values mirror the decoder's encoding; this block only
//   consumes them and must stay in step with the decoder.
package alu_cdb_stage_pkg;

   localparam int unsigned DATA_WIDTH          = 32;
   localparam int unsigned ROB_TAG_WIDTH       = 4;
   localparam int unsigned INSIDE_OPCODE_WIDTH = 6;

   localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_ADD  = 6'd1;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SUB  = 6'd2;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLL  = 6'd3;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLT  = 6'd4;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLTU = 6'd5;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_XOR  = 6'd6;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRL  = 6'd7;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRA  = 6'd8;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_OR   = 6'd9;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_AND  = 6'd10;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BEQ  = 6'd11;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BNE  = 6'd12;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BLT  = 6'd13;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BGE  = 6'd14;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BLTU = 6'd15;
   localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BGEU = 6'd16;

endpackage

// File: rtl/alu_cdb_stage_fifo.sv
// alu_result_fifo
//   In-order result buffer with simultaneous push/pop and flush.
//   Ports:
//     clk, rst     clock (rising edge), asynchronous active-low reset
//     en           clock enable; push/pop ignored when 0
//     flush        empties the buffer on the edge, independent of en
//     push, pop    write at tail / advance head (gated by full / empty)
//     push_data    entry written on push
//     head_data    entry at head (stale when empty; caller masks)
//     full, empty  occupancy flags derived from the registered count
module alu_result_fifo
   import alu_cdb_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign head_data = mem_q[head_q];

   assign do_push = en & ~flush & push & ~full;
   assign do_pop  = en & ~flush & pop & ~empty;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[tail_q] = push_data;
            // DEPTH is a power of two, so the natural pointer overflow wraps
            tail_d = tail_q + PTR_W'(1);
         end
         if (do_pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/alu_cdb_stage.sv
// alu_cdb_stage
//   ALU execution stage between the ALU reservation station and the CDB.
//   Computes the result of an accepted issue in the same cycle, buffers
//   {tag, result} in an in-order FIFO and offers the head to the CDB
//   arbiter with a valid/grant handshake.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     rdy                      global clock enable (flush/reset still act)
//     in_flush                 ROB flush, empties the buffer
//     in_rs_valid/out_rs_ready issue handshake with the reservation station
//     in_rs_op/value1/value2   opcode and operands
//     in_rs_rob_tag            destination ROB tag (0 = null, ignored)
//     out_cdb_valid/tag/value  head result offered to the CDB
//     in_cdb_grant             arbiter grant; pops the head
module alu_cdb_stage
   import alu_cdb_stage_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_WIDTH,
   parameter int unsigned TAG_W      = ROB_TAG_WIDTH,
   parameter int unsigned OP_W       = INSIDE_OPCODE_WIDTH,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              in_flush,
   input  logic              in_rs_valid,
   output logic              out_rs_ready,
   input  logic [OP_W-1:0]   in_rs_op,
   input  logic [DATA_W-1:0] in_rs_value1,
   input  logic [DATA_W-1:0] in_rs_value2,
   input  logic [TAG_W-1:0]  in_rs_rob_tag,
   output logic              out_cdb_valid,
   output logic [TAG_W-1:0]  out_cdb_tag,
   output logic [DATA_W-1:0] out_cdb_value,
   input  logic              in_cdb_grant
);

   localparam int unsigned ENTRY_W = TAG_W + DATA_W;

   logic              accept;
   logic              pop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] result;
   logic [4:0]        shamt;
   logic              cond;
   logic [ENTRY_W-1:0] head_entry;

   assign out_rs_ready  = ~fifo_full;
   assign out_cdb_valid = ~fifo_empty;

   assign accept = in_rs_valid & out_rs_ready & rdy & ~in_flush &
                   (in_rs_rob_tag != TAG_W'(ZERO_TAG_ROB));
   assign pop    = out_cdb_valid & in_cdb_grant & rdy;

   assign shamt = in_rs_value2[4:0];

   always_comb begin
      result = '0;
      cond   = FALSE;
      case (in_rs_op)
         OP_ADD:  result = in_rs_value1 + in_rs_value2;
         OP_SUB:  result = in_rs_value1 - in_rs_value2;
         OP_SLL:  result = in_rs_value1 << shamt;
         OP_SRL:  result = in_rs_value1 >> shamt;
         OP_SRA:  result = $signed(in_rs_value1) >>> shamt;
         OP_XOR:  result = in_rs_value1 ^ in_rs_value2;
         OP_OR:   result = in_rs_value1 | in_rs_value2;
         OP_AND:  result = in_rs_value1 & in_rs_value2;
         OP_SLT, OP_BLT:   cond = ($signed(in_rs_value1) <  $signed(in_rs_value2));
         OP_BGE:           cond = ($signed(in_rs_value1) >= $signed(in_rs_value2));
         OP_SLTU, OP_BLTU: cond = (in_rs_value1 <  in_rs_value2);
         OP_BGEU:          cond = (in_rs_value1 >= in_rs_value2);
         OP_BEQ:           cond = (in_rs_value1 == in_rs_value2);
         OP_BNE:           cond = (in_rs_value1 != in_rs_value2);
         default: result = '0;
      endcase
      // compare-class ops produce a 0/1 result through cond
      if (cond) begin
         result = DATA_W'(1);
      end
   end

   alu_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .en        (rdy),
      .flush     (in_flush),
      .push      (accept),
      .pop       (pop),
      .push_data ({in_rs_rob_tag, result}),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // stale storage behind an empty buffer must not leak onto the CDB
   assign out_cdb_tag   = fifo_empty ? '0 : head_entry[ENTRY_W-1:DATA_W];
   assign out_cdb_value = fifo_empty ? '0 : head_entry[DATA_W-1:0];

endmodule

// File: tb/tb_alu_cdb_stage.sv
module tb_alu_cdb_stage;
   import alu_cdb_stage_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        in_flush = 1'b0;
   logic        in_rs_valid = 1'b0;
   logic        out_rs_ready;
   logic [5:0]  in_rs_op = '0;
   logic [31:0] in_rs_value1 = '0;
   logic [31:0] in_rs_value2 = '0;
   logic [3:0]  in_rs_rob_tag = '0;
   logic        out_cdb_valid;
   logic [3:0]  out_cdb_tag;
   logic [31:0] out_cdb_value;
   logic        in_cdb_grant = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_cdb_stage #(.DATA_W(32), .TAG_W(4), .OP_W(6), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
      .in_rs_valid(in_rs_valid), .out_rs_ready(out_rs_ready),
      .in_rs_op(in_rs_op), .in_rs_value1(in_rs_value1),
      .in_rs_value2(in_rs_value2), .in_rs_rob_tag(in_rs_rob_tag),
      .out_cdb_valid(out_cdb_valid), .out_cdb_tag(out_cdb_tag),
      .out_cdb_value(out_cdb_value), .in_cdb_grant(in_cdb_grant)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU written from the operation definitions
   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic        lt_s, lt_u;
      sh   = int'(b[4:0]);
      lt_u = (a < b);
      lt_s = (a[31] != b[31]) ? a[31] : lt_u;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a + ~b + 32'd1;
         OP_SLL:  return a << sh;
         OP_SRL:  return a >> sh;
         OP_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         OP_XOR:  return a ^ b;
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         OP_SLT, OP_BLT:   return {31'd0, lt_s};
         OP_BGE:           return {31'd0, ~lt_s};
         OP_SLTU, OP_BLTU: return {31'd0, lt_u};
         OP_BGEU:          return {31'd0, ~lt_u};
         OP_BEQ:           return {31'd0, a == b};
         OP_BNE:           return {31'd0, a != b};
         default:          return 32'd0;
      endcase
   endfunction

   // Behavioural model: queue of {tag, value} in acceptance order
   logic [35:0] mq[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
      end else if (in_flush) begin
         mq.delete();
      end else if (rdy) begin
         bit do_pop, do_push;
         do_pop  = (mq.size() != 0) && in_cdb_grant;
         do_push = in_rs_valid && (mq.size() < DEPTH) && (in_rs_rob_tag != 4'd0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back({in_rs_rob_tag, ref_alu(in_rs_op, in_rs_value1, in_rs_value2)});
      end
   end

   // Compare process: outputs against the model every cycle
   always @(negedge clk) begin
      logic [35:0] head;
      head = (mq.size() != 0) ? mq[0] : 36'd0;
      check("cdb_valid", {31'd0, out_cdb_valid}, {31'd0, mq.size() != 0});
      check("cdb_tag",   {28'd0, out_cdb_tag},   {28'd0, head[35:32]});
      check("cdb_value", out_cdb_value,          head[31:0]);
      if (rst) check("rs_ready", {31'd0, out_rs_ready}, {31'd0, mq.size() < DEPTH});
   end

   // Drive one cycle of inputs (called at a negedge, returns at the next)
   task automatic cyc(input logic v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] t, input logic g);
      in_rs_valid = v; in_rs_op = op; in_rs_value1 = a; in_rs_value2 = b;
      in_rs_rob_tag = t; in_cdb_grant = g;
      @(negedge clk);
   endtask

   task automatic idle(input logic g, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 32'd0, 32'd0, 4'd0, g);
   endtask

   // Issue into an empty buffer with grant held: result visible next cycle
   task automatic op_lit(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t, input logic [31:0] exp);
      cyc(1'b1, op, a, b, t, 1'b1);
      check({name, "_tag"}, {28'd0, out_cdb_tag}, {28'd0, t});
      check(name, out_cdb_value, exp);
      idle(1'b1, 1);
   endtask

   initial begin
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_valid", {31'd0, out_cdb_valid}, 32'd0);
      check("reset_tag",   {28'd0, out_cdb_tag},   32'd0);
      check("reset_value", out_cdb_value,          32'd0);
      check("reset_ready", {31'd0, out_rs_ready},  32'd1);

      // ADD latency and pop
      cyc(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3, 1'b1);
      check("add_valid", {31'd0, out_cdb_valid}, 32'd1);
      check("add_tag",   {28'd0, out_cdb_tag},   32'd3);
      check("add_value", out_cdb_value,          32'd12);
      idle(1'b1, 1);
      check("add_popped", {31'd0, out_cdb_valid}, 32'd0);

      // shifts and compares
      op_lit("sra",  OP_SRA,  32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000);
      op_lit("srl",  OP_SRL,  32'h8000_0000, 32'd4, 4'd2, 32'h0800_0000);
      op_lit("sll",  OP_SLL,  32'h8000_0000, 32'd4, 4'd3, 32'h0000_0000);
      op_lit("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1);
      op_lit("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0);
      op_lit("bgeu", OP_BGEU, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd1);
      op_lit("sub",  OP_SUB,  32'd0,         32'd1, 4'd7, 32'hFFFF_FFFF);
      op_lit("undef", 6'd63,  32'd9,         32'd9, 4'd8, 32'd0);

      // back-pressure
      for (int t = 1; t <= 4; t++) cyc(1'b1, OP_ADD, 32'(t), 32'd100, 4'(t), 1'b0);
      check("bp_ready_low", {31'd0, out_rs_ready}, 32'd0);
      cyc(1'b1, OP_ADD, 32'd5, 32'd100, 4'd5, 1'b0);
      for (int t = 1; t <= 4; t++) begin
         check("bp_order_tag", {28'd0, out_cdb_tag}, 32'(t));
         check("bp_order_val", out_cdb_value, 32'(t + 100));
         cyc(1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
         if (t == 1) check("bp_ready_back", {31'd0, out_rs_ready}, 32'd1);
      end
      check("bp_drained", {31'd0, out_cdb_valid}, 32'd0);

      // simultaneous push/pop at count 3 and across pointer wraps
      for (int t = 1; t <= 3; t++) cyc(1'b1, OP_XOR, 32'(t), 32'd0, 4'(t), 1'b0);
      cyc(1'b1, OP_OR, 32'd7, 32'd0, 4'd7, 1'b1);
      check("sim_ready", {31'd0, out_rs_ready}, 32'd1);
      for (int t = 0; t < 10; t++) cyc(1'b1, OP_ADD, 32'(t), 32'd1, 4'(t % 15 + 1), 1'b1);
      idle(1'b1, 5);

      // flush with concurrent issue and grant
      for (int t = 1; t <= 3; t++) cyc(1'b1, OP_AND, 32'hFF, 32'(t), 4'(t), 1'b0);
      in_flush = 1'b1;
      cyc(1'b1, OP_ADD, 32'd1, 32'd1, 4'd9, 1'b1);
      in_flush = 1'b0;
      check("flush_valid", {31'd0, out_cdb_valid}, 32'd0);
      check("flush_ready", {31'd0, out_rs_ready},  32'd1);
      idle(1'b1, 3);

      // freeze with rdy=0
      cyc(1'b1, OP_ADD, 32'd10, 32'd1, 4'd10, 1'b0);
      cyc(1'b1, OP_ADD, 32'd20, 32'd1, 4'd11, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, OP_ADD, 32'd30, 32'd1, 4'd12, 1'b1);
         check("frz_tag",   {28'd0, out_cdb_tag}, 32'd10);
         check("frz_value", out_cdb_value,        32'd11);
      end
      rdy = 1'b1;
      idle(1'b1, 1);
      check("frz_second", {28'd0, out_cdb_tag}, 32'd11);
      idle(1'b1, 1);
      check("frz_empty", {31'd0, out_cdb_valid}, 32'd0);

      // null tag
      cyc(1'b1, OP_ADD, 32'd1, 32'd2, 4'd0, 1'b0);
      check("null_tag", {31'd0, out_cdb_valid}, 32'd0);

      // asynchronous reset mid-cycle
      cyc(1'b1, OP_ADD, 32'd1, 32'd2, 4'd13, 1'b0);
      cyc(1'b1, OP_ADD, 32'd3, 32'd4, 4'd14, 1'b0);
      in_rs_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_cdb_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, out_rs_ready}, 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 7) == 0) b = $urandom_range(0, 40);
         rdy      = ($urandom_range(0, 9) != 0);
         in_flush = ($urandom_range(0, 39) == 0);
         cyc($urandom_range(0, 3) != 0, 6'($urandom_range(0, 20)), a, b,
             4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
      end
      rdy = 1'b1; in_flush = 1'b0;
      idle(1'b1, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
